// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// issue_scoreboard: dual-issue register scoreboard, hazard stall generation
// and sticky slot-0 stall-timeout detection.
// Optional feature macro: ISSUE_SCB_WB_BYPASS_EN (same-cycle writeback masks RAW).
// Revision: 1.0
// ============================================================================
module issue_scoreboard #(
    parameter int STALL_TIMEOUT = 1024,
    parameter int NUM_UNITS     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 inst0_valid_i,
    input  logic                 inst0_rs1_valid_i,
    input  logic                 inst0_rs2_valid_i,
    input  logic                 inst0_rs3_valid_i,
    input  logic [4:0]           inst0_rs1_i,
    input  logic [4:0]           inst0_rs2_i,
    input  logic [4:0]           inst0_rs3_i,
    input  logic [2:0]           inst0_src_fp_i,
    input  logic [1:0]           inst0_rd_type_i,
    input  logic [4:0]           inst0_rd_i,
    input  logic [NUM_UNITS-1:0] inst0_exe_unit_i,
    input  logic                 inst1_valid_i,
    input  logic                 inst1_rs1_valid_i,
    input  logic                 inst1_rs2_valid_i,
    input  logic                 inst1_rs3_valid_i,
    input  logic [4:0]           inst1_rs1_i,
    input  logic [4:0]           inst1_rs2_i,
    input  logic [4:0]           inst1_rs3_i,
    input  logic [2:0]           inst1_src_fp_i,
    input  logic [1:0]           inst1_rd_type_i,
    input  logic [4:0]           inst1_rd_i,
    input  logic [NUM_UNITS-1:0] inst1_exe_unit_i,
    input  logic [NUM_UNITS-1:0] unit_busy_i,
    input  logic                 wb0_valid_i,
    input  logic [1:0]           wb0_rd_type_i,
    input  logic [4:0]           wb0_rd_i,
    input  logic                 wb1_valid_i,
    input  logic [1:0]           wb1_rd_type_i,
    input  logic [4:0]           wb1_rd_i,
    output logic                 stall_inst0_o,
    output logic                 stall_inst1_o,
    output logic                 issue_inst0_o,
    output logic                 issue_inst1_o,
    output logic                 deadlock_o
);

    localparam int              CNT_W    = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);

    logic [31:1]      pend_int;
    logic [31:0]      pend_fp;
    logic [CNT_W-1:0] stall_cnt;

    logic [31:0] pend_int_all, raw_int, raw_fp;
    logic [31:0] wb_int_vec, wb_fp_vec, set_int, set_fp;
    logic        rd0_int, rd0_fp, rd1_int, rd1_fp;
    logic        h0, h1, intra;
    logic        unused;

    function automatic logic [31:0] onehot(input logic en, input logic [4:0] idx);
        onehot = en ? (32'd1 << idx) : 32'd0;
    endfunction

    function automatic logic src_haz(input logic v, input logic [4:0] idx, input logic fp,
                                     input logic [31:0] pi, input logic [31:0] pf);
        src_haz = v && (fp ? pf[idx] : pi[idx]);
    endfunction

    // Slot-1 source against slot-0 destination of the same register file.
    function automatic logic pair_match(input logic v, input logic [4:0] idx, input logic fp,
                                        input logic [4:0] rd, input logic d_int, input logic d_fp);
        pair_match = v && (idx == rd) && (fp ? d_fp : d_int);
    endfunction

    assign unused       = &{1'b0, inst0_src_fp_i[2], inst1_src_fp_i[2]};
    assign pend_int_all = {pend_int, 1'b0};

    assign rd0_int = (inst0_rd_type_i == 2'b01) && (inst0_rd_i != 5'd0);
    assign rd0_fp  = (inst0_rd_type_i == 2'b10);
    assign rd1_int = (inst1_rd_type_i == 2'b01) && (inst1_rd_i != 5'd0);
    assign rd1_fp  = (inst1_rd_type_i == 2'b10);

    assign wb_int_vec = onehot(wb0_valid_i && wb0_rd_type_i == 2'b01 && wb0_rd_i != 5'd0, wb0_rd_i)
                      | onehot(wb1_valid_i && wb1_rd_type_i == 2'b01 && wb1_rd_i != 5'd0, wb1_rd_i);
    assign wb_fp_vec  = onehot(wb0_valid_i && wb0_rd_type_i == 2'b10, wb0_rd_i)
                      | onehot(wb1_valid_i && wb1_rd_type_i == 2'b10, wb1_rd_i);

`ifdef ISSUE_SCB_WB_BYPASS_EN
    assign raw_int = pend_int_all & ~wb_int_vec;
    assign raw_fp  = pend_fp & ~wb_fp_vec;
`else
    assign raw_int = pend_int_all;
    assign raw_fp  = pend_fp;
`endif

    always_comb begin
        h0 = src_haz(inst0_rs1_valid_i, inst0_rs1_i, inst0_src_fp_i[0], raw_int, raw_fp)
           | src_haz(inst0_rs2_valid_i, inst0_rs2_i, inst0_src_fp_i[1], raw_int, raw_fp)
           | src_haz(inst0_rs3_valid_i, inst0_rs3_i, 1'b1, raw_int, raw_fp)
           | (rd0_int && pend_int_all[inst0_rd_i])
           | (rd0_fp && pend_fp[inst0_rd_i])
           | (|(inst0_exe_unit_i & unit_busy_i));

        intra = pair_match(inst1_rs1_valid_i, inst1_rs1_i, inst1_src_fp_i[0], inst0_rd_i, rd0_int, rd0_fp)
              | pair_match(inst1_rs2_valid_i, inst1_rs2_i, inst1_src_fp_i[1], inst0_rd_i, rd0_int, rd0_fp)
              | pair_match(inst1_rs3_valid_i, inst1_rs3_i, 1'b1, inst0_rd_i, rd0_int, rd0_fp)
              | ((inst1_rd_i == inst0_rd_i) && ((rd1_int && rd0_int) || (rd1_fp && rd0_fp)))
              | (|(inst0_exe_unit_i & inst1_exe_unit_i));

        h1 = src_haz(inst1_rs1_valid_i, inst1_rs1_i, inst1_src_fp_i[0], raw_int, raw_fp)
           | src_haz(inst1_rs2_valid_i, inst1_rs2_i, inst1_src_fp_i[1], raw_int, raw_fp)
           | src_haz(inst1_rs3_valid_i, inst1_rs3_i, 1'b1, raw_int, raw_fp)
           | (rd1_int && pend_int_all[inst1_rd_i])
           | (rd1_fp && pend_fp[inst1_rd_i])
           | (|(inst1_exe_unit_i & unit_busy_i))
           | (inst0_valid_i && intra);
    end

    assign stall_inst0_o = inst0_valid_i && h0 && !flush_i;
    assign stall_inst1_o = inst1_valid_i && (h1 || stall_inst0_o) && !flush_i;
    assign issue_inst0_o = inst0_valid_i && !stall_inst0_o && !flush_i;
    assign issue_inst1_o = inst1_valid_i && !stall_inst1_o && !flush_i;

    assign set_int = onehot(issue_inst0_o && rd0_int, inst0_rd_i) | onehot(issue_inst1_o && rd1_int, inst1_rd_i);
    assign set_fp  = onehot(issue_inst0_o && rd0_fp, inst0_rd_i)  | onehot(issue_inst1_o && rd1_fp, inst1_rd_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_int   <= '0;
            pend_fp    <= '0;
            stall_cnt  <= '0;
            deadlock_o <= 1'b0;
        end else if (flush_i) begin
            pend_int   <= '0;
            pend_fp    <= '0;
            stall_cnt  <= '0;
            deadlock_o <= 1'b0;
        end else begin
            // Set is OR-ed after the clear so an issuing producer wins.
            pend_int <= (pend_int & ~wb_int_vec[31:1]) | set_int[31:1];
            pend_fp  <= (pend_fp & ~wb_fp_vec) | set_fp;
            if (stall_inst0_o) begin
                if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
                if (stall_cnt == CNT_LAST) deadlock_o <= 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_issue_scoreboard: directed self-checking bench for issue_scoreboard.
// Revision: 1.0
// ============================================================================
module tb_issue_scoreboard;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_i;
    logic inst0_valid_i, inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i;
    logic [4:0] inst0_rs1_i, inst0_rs2_i, inst0_rs3_i, inst0_rd_i;
    logic [2:0] inst0_src_fp_i;
    logic [1:0] inst0_rd_type_i;
    logic [5:0] inst0_exe_unit_i;
    logic inst1_valid_i, inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i;
    logic [4:0] inst1_rs1_i, inst1_rs2_i, inst1_rs3_i, inst1_rd_i;
    logic [2:0] inst1_src_fp_i;
    logic [1:0] inst1_rd_type_i;
    logic [5:0] inst1_exe_unit_i;
    logic [5:0] unit_busy_i;
    logic wb0_valid_i, wb1_valid_i;
    logic [1:0] wb0_rd_type_i, wb1_rd_type_i;
    logic [4:0] wb0_rd_i, wb1_rd_i;
    logic stall_inst0_o, stall_inst1_o, issue_inst0_o, issue_inst1_o, deadlock_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    issue_scoreboard #(.STALL_TIMEOUT(8), .NUM_UNITS(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .inst0_valid_i(inst0_valid_i), .inst0_rs1_valid_i(inst0_rs1_valid_i),
        .inst0_rs2_valid_i(inst0_rs2_valid_i), .inst0_rs3_valid_i(inst0_rs3_valid_i),
        .inst0_rs1_i(inst0_rs1_i), .inst0_rs2_i(inst0_rs2_i), .inst0_rs3_i(inst0_rs3_i),
        .inst0_src_fp_i(inst0_src_fp_i), .inst0_rd_type_i(inst0_rd_type_i),
        .inst0_rd_i(inst0_rd_i), .inst0_exe_unit_i(inst0_exe_unit_i),
        .inst1_valid_i(inst1_valid_i), .inst1_rs1_valid_i(inst1_rs1_valid_i),
        .inst1_rs2_valid_i(inst1_rs2_valid_i), .inst1_rs3_valid_i(inst1_rs3_valid_i),
        .inst1_rs1_i(inst1_rs1_i), .inst1_rs2_i(inst1_rs2_i), .inst1_rs3_i(inst1_rs3_i),
        .inst1_src_fp_i(inst1_src_fp_i), .inst1_rd_type_i(inst1_rd_type_i),
        .inst1_rd_i(inst1_rd_i), .inst1_exe_unit_i(inst1_exe_unit_i),
        .unit_busy_i(unit_busy_i),
        .wb0_valid_i(wb0_valid_i), .wb0_rd_type_i(wb0_rd_type_i), .wb0_rd_i(wb0_rd_i),
        .wb1_valid_i(wb1_valid_i), .wb1_rd_type_i(wb1_rd_type_i), .wb1_rd_i(wb1_rd_i),
        .stall_inst0_o(stall_inst0_o), .stall_inst1_o(stall_inst1_o),
        .issue_inst0_o(issue_inst0_o), .issue_inst1_o(issue_inst1_o),
        .deadlock_o(deadlock_o)
    );

    task automatic clear_inputs();
        flush_i = 0; unit_busy_i = '0;
        inst0_valid_i = 0; inst0_rs1_valid_i = 0; inst0_rs2_valid_i = 0; inst0_rs3_valid_i = 0;
        inst0_rs1_i = 0; inst0_rs2_i = 0; inst0_rs3_i = 0; inst0_src_fp_i = 0;
        inst0_rd_type_i = 0; inst0_rd_i = 0; inst0_exe_unit_i = 6'b000001;
        inst1_valid_i = 0; inst1_rs1_valid_i = 0; inst1_rs2_valid_i = 0; inst1_rs3_valid_i = 0;
        inst1_rs1_i = 0; inst1_rs2_i = 0; inst1_rs3_i = 0; inst1_src_fp_i = 0;
        inst1_rd_type_i = 0; inst1_rd_i = 0; inst1_exe_unit_i = 6'b000010;
        wb0_valid_i = 0; wb0_rd_type_i = 0; wb0_rd_i = 0;
        wb1_valid_i = 0; wb1_rd_type_i = 0; wb1_rd_i = 0;
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow #1.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0; clear_inputs(); #1;
        tests++; if (deadlock_o !== 1'b0) begin fails++; $display("FAIL reset_deadlock got %b exp 0", deadlock_o); end
        tests++; if ({stall_inst0_o, stall_inst1_o, issue_inst0_o, issue_inst1_o} !== 4'b0000) begin
            fails++; $display("FAIL reset_outputs got %b exp 0000", {stall_inst0_o, stall_inst1_o, issue_inst0_o, issue_inst1_o}); end
        step(); step(); rst_n = 1; step();
        inst0_valid_i = 1; inst0_rs1_valid_i = 1; inst0_rs1_i = 5; inst0_rs3_valid_i = 1; inst0_rs3_i = 5; #1;
        tests++; if (issue_inst0_o !== 1'b1) begin fails++; $display("FAIL reset_empty_issue got %b exp 1", issue_inst0_o); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        step();
        inst0_valid_i = 1; inst0_rd_type_i = 2'b01; inst0_rd_i = 5; #1;
        tests++; if (issue_inst0_o !== 1'b1) begin fails++; $display("FAIL b2b_producer got %b exp 1", issue_inst0_o); end
        step();
        inst0_rd_type_i = 2'b00; inst0_rd_i = 0; inst0_rs1_valid_i = 1; inst0_rs1_i = 5; inst0_exe_unit_i = 6'b000010; #1;
        tests++; if (stall_inst0_o !== 1'b1) begin fails++; $display("FAIL b2b_c1_stall got %b exp 1", stall_inst0_o); end
        step(); #1;
        tests++; if (stall_inst0_o !== 1'b1) begin fails++; $display("FAIL b2b_c2_stall got %b exp 1", stall_inst0_o); end
        step();
        wb0_valid_i = 1; wb0_rd_type_i = 2'b01; wb0_rd_i = 5; #1;
`ifdef ISSUE_SCB_WB_BYPASS_EN
        tests++; if (issue_inst0_o !== 1'b1) begin fails++; $display("FAIL b2b_c3_issue got %b exp 1", issue_inst0_o); end
`else
        tests++; if (stall_inst0_o !== 1'b1) begin fails++; $display("FAIL b2b_c3_stall got %b exp 1", stall_inst0_o); end
`endif
        step();
        wb0_valid_i = 0; #1;
        tests++; if (issue_inst0_o !== 1'b1) begin fails++; $display("FAIL b2b_c4_issue got %b exp 1", issue_inst0_o); end
        clear_inputs();
    endtask

    task automatic test_intra_pair();
        step();
        inst0_valid_i = 1; inst0_rd_type_i = 2'b01; inst0_rd_i = 7;
        inst1_valid_i = 1; inst1_rs2_valid_i = 1; inst1_rs2_i = 7; #1;
        tests++; if ({issue_inst0_o, stall_inst1_o, issue_inst1_o} !== 3'b110) begin
            fails++; $display("FAIL intra_pair got %b exp 110", {issue_inst0_o, stall_inst1_o, issue_inst1_o}); end
        step();
        inst0_valid_i = 0; #1;
        tests++; if (stall_inst1_o !== 1'b1) begin fails++; $display("FAIL intra_pending1 got %b exp 1", stall_inst1_o); end
        step(); #1;
        tests++; if (stall_inst1_o !== 1'b1) begin fails++; $display("FAIL intra_pending2 got %b exp 1", stall_inst1_o); end
        step();
        wb1_valid_i = 1; wb1_rd_type_i = 2'b01; wb1_rd_i = 7; #1;
`ifdef ISSUE_SCB_WB_BYPASS_EN
        tests++; if (issue_inst1_o !== 1'b1) begin fails++; $display("FAIL intra_wb_issue got %b exp 1", issue_inst1_o); end
`else
        tests++; if (stall_inst1_o !== 1'b1) begin fails++; $display("FAIL intra_wb_stall got %b exp 1", stall_inst1_o); end
`endif
        step();
        wb1_valid_i = 0; #1;
        tests++; if (issue_inst1_o !== 1'b1) begin fails++; $display("FAIL intra_after_wb got %b exp 1", issue_inst1_o); end
        clear_inputs();
    endtask

    task automatic test_file_sep();
        step();
        inst0_valid_i = 1; inst0_rd_type_i = 2'b10; inst0_rd_i = 3; #1;
        tests++; if (issue_inst0_o !== 1'b1) begin fails++; $display("FAIL fp_producer got %b exp 1", issue_inst0_o); end
        step();
        inst0_rd_type_i = 2'b00; inst0_rd_i = 0; inst0_rs1_valid_i = 1; inst0_rs1_i = 3; #1;
        tests++; if (stall_inst0_o !== 1'b0) begin fails++; $display("FAIL file_int_read got %b exp 0", stall_inst0_o); end
        inst0_src_fp_i = 3'b001; #1;
        tests++; if (stall_inst0_o !== 1'b1) begin fails++; $display("FAIL file_fp_rs1 got %b exp 1", stall_inst0_o); end
        inst0_src_fp_i = 3'b000; inst0_rs1_valid_i = 0; inst0_rs3_valid_i = 1; inst0_rs3_i = 3; #1;
        tests++; if (stall_inst0_o !== 1'b1) begin fails++; $display("FAIL file_fp_rs3 got %b exp 1", stall_inst0_o); end
        inst0_rs3_valid_i = 0; inst0_rd_type_i = 2'b10; inst0_rd_i = 3; #1;
        tests++; if (stall_inst0_o !== 1'b1) begin fails++; $display("FAIL file_fp_waw got %b exp 1", stall_inst0_o); end
        inst0_valid_i = 0; wb0_valid_i = 1; wb0_rd_type_i = 2'b10; wb0_rd_i = 3;
        step();
        clear_inputs();
    endtask

    task automatic test_x0();
        step();
        inst0_valid_i = 1; inst0_rd_type_i = 2'b01; inst0_rd_i = 0; #1;
        tests++; if (issue_inst0_o !== 1'b1) begin fails++; $display("FAIL x0_issue got %b exp 1", issue_inst0_o); end
        step();
        inst0_rs1_valid_i = 1; inst0_rs1_i = 0; #1;
        tests++; if (stall_inst0_o !== 1'b0) begin fails++; $display("FAIL x0_not_pending got %b exp 0", stall_inst0_o); end
        clear_inputs();
    endtask

    task automatic test_structural();
        step();
        inst0_valid_i = 1; inst1_valid_i = 1; inst0_exe_unit_i = 6'b000100; inst1_exe_unit_i = 6'b000100; #1;
        tests++; if ({issue_inst0_o, stall_inst1_o} !== 2'b11) begin
            fails++; $display("FAIL struct_pair got %b exp 11", {issue_inst0_o, stall_inst1_o}); end
        inst1_exe_unit_i = 6'b001000; unit_busy_i = 6'b000100; #1;
        tests++; if ({stall_inst0_o, stall_inst1_o, issue_inst0_o} !== 3'b110) begin
            fails++; $display("FAIL struct_busy got %b exp 110", {stall_inst0_o, stall_inst1_o, issue_inst0_o}); end
        clear_inputs();
    endtask

    task automatic test_flush();
        step();
        inst0_valid_i = 1; inst0_rd_type_i = 2'b01; inst0_rd_i = 1;
        inst1_valid_i = 1; inst1_rd_type_i = 2'b01; inst1_rd_i = 2; #1;
        tests++; if ({issue_inst0_o, issue_inst1_o} !== 2'b11) begin
            fails++; $display("FAIL flush_setup got %b exp 11", {issue_inst0_o, issue_inst1_o}); end
        step();
        inst0_rd_type_i = 0; inst0_rd_i = 0; inst1_rd_type_i = 0; inst1_rd_i = 0;
        inst0_rs1_valid_i = 1; inst0_rs1_i = 1; inst1_rs1_valid_i = 1; inst1_rs1_i = 2;
        flush_i = 1; wb1_valid_i = 1; wb1_rd_type_i = 2'b01; wb1_rd_i = 1; #1;
        tests++; if ({stall_inst0_o, stall_inst1_o, issue_inst0_o, issue_inst1_o} !== 4'b0000) begin
            fails++; $display("FAIL flush_outputs got %b exp 0000", {stall_inst0_o, stall_inst1_o, issue_inst0_o, issue_inst1_o}); end
        step();
        flush_i = 0; wb1_valid_i = 0; inst0_rs2_valid_i = 1; inst0_rs2_i = 2; #1;
        tests++; if ({issue_inst0_o, issue_inst1_o} !== 2'b11) begin
            fails++; $display("FAIL flush_empty got %b exp 11", {issue_inst0_o, issue_inst1_o}); end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        step();
        inst0_valid_i = 1; inst0_rd_type_i = 2'b01; inst0_rd_i = 9;
        step();
        inst0_rd_type_i = 0; inst0_rd_i = 0; inst0_rs1_valid_i = 1; inst0_rs1_i = 9; #1;
        tests++; if (stall_inst0_o !== 1'b1) begin fails++; $display("FAIL arst_pre_stall got %b exp 1", stall_inst0_o); end
        rst_n = 0; #1;
        tests++; if ({stall_inst0_o, issue_inst0_o} !== 2'b01) begin
            fails++; $display("FAIL arst_cleared got %b exp 01", {stall_inst0_o, issue_inst0_o}); end
        #1 rst_n = 1;
        clear_inputs();
    endtask

    task automatic test_deadlock();
        step();
        inst0_valid_i = 1; inst0_rd_type_i = 2'b01; inst0_rd_i = 10;
        step();
        inst0_rd_type_i = 0; inst0_rd_i = 0; inst0_rs1_valid_i = 1; inst0_rs1_i = 10;
        for (int i = 1; i <= 8; i++) begin
            #1;
            tests++; if ({stall_inst0_o, deadlock_o} !== 2'b10) begin
                fails++; $display("FAIL deadlock_cycle%0d got %b exp 10", i, {stall_inst0_o, deadlock_o}); end
            step();
        end
        #1;
        tests++; if (deadlock_o !== 1'b1) begin fails++; $display("FAIL deadlock_set got %b exp 1", deadlock_o); end
        inst0_valid_i = 0;
        step(); step(); #1;
        tests++; if (deadlock_o !== 1'b1) begin fails++; $display("FAIL deadlock_sticky got %b exp 1", deadlock_o); end
        flush_i = 1;
        step();
        flush_i = 0; #1;
        tests++; if (deadlock_o !== 1'b0) begin fails++; $display("FAIL deadlock_flush got %b exp 0", deadlock_o); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_intra_pair();
        test_file_sep();
        test_x0();
        test_structural();
        test_flush();
        test_async_reset();
        test_deadlock();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
